noc_packetizer: RTL
===================

// Module: noc_packetizer
// PURPOSE
//  Sits between lx_noc_interface (cache-hierarchy side) and a NoC router port. Outbound: latches
//  one cache-line message (msg, address, line, dest id) and serializes it into flits. Inbound:
//  reassembles flits into one message and hands it to the interface. The two directions run independently.
// PARAMETERS
//  MSG_BITS      4    message field width
//  ADDRESS_BITS  32   address width, <= FLIT_WIDTH
//  DATA_WIDTH    32   word width; also flit width (FLIT_WIDTH == DATA_WIDTH)
//  OFFSET_BITS   2    log2 words per line; WORDS = 1<<OFFSET_BITS; LINE = WORDS*DATA_WIDTH
//  ID_BITS       2    node id width; 2*ID_BITS+MSG_BITS <= FLIT_WIDTH
//  LOCAL_ID      0    this node's id
//  IDLE_MSG      0    msg encoding meaning "no message"
// PORTS
//  clock            in   1            clock
//  reset            in   1            synchronous, active-low reset
//  noc_msg_out      in   MSG_BITS     tx message from interface; != IDLE_MSG means request
//  noc_address_out  in   ADDRESS_BITS tx address
//  noc_data_out     in   LINE         tx line
//  noc_dest_id      in   ID_BITS      tx destination node
//  packetizer_busy  out  1            tx cannot accept a message
//  noc_msg_in       out  MSG_BITS     rx message to interface
//  noc_address_in   out  ADDRESS_BITS rx address
//  noc_data_in      out  LINE         rx line
//  noc_src_id       out  ID_BITS      rx source node
//  interface_busy   in   1            interface cannot take an rx message
//  flit_out         out  DATA_WIDTH   tx flit
//  flit_out_valid   out  1            tx flit valid
//  flit_out_ready   in   1            router accepts tx flit
//  flit_in          in   DATA_WIDTH   rx flit
//  flit_in_valid    in   1            rx flit valid
//  flit_in_ready    out  1            packetizer accepts rx flit
//  drop_pulse       out  1            1-cycle pulse: rx packet with wrong dest discarded
// BEHAVIOUR
//  Packet format: every packet has 2+WORDS flits, in this order: HEAD, ADDR, D0..D(WORDS-1).
//   HEAD: [W-1 -: ID_BITS] = dest; next ID_BITS = src; next MSG_BITS = msg; remaining bits 0.
//   ADDR: address, zero-extended. Dk: line word k, bits [k*DATA_WIDTH +: DATA_WIDTH], D0 sent first.
//  Flit handshake: a flit transfers on a cycle with valid&&ready. While valid is high, the flit
//   is held stable and valid is not dropped.
//  TX FSM: TX_IDLE -> TX_HEAD -> TX_ADDR -> TX_DATA(cnt 0..WORDS-1) -> TX_IDLE.
//   - Accept when state==TX_IDLE && noc_msg_out!=IDLE_MSG. Latch msg/addr/line/dest; src=LOCAL_ID.
//   - packetizer_busy = (state!=TX_IDLE), registered. It rises the cycle after accept.
//   - flit_out_valid is high in TX_HEAD/ADDR/DATA. It first rises the cycle after accept.
//   - After the last data flit transfers: TX_IDLE and busy=0 the next cycle. If a new request is
//     present in that TX_IDLE cycle, it is accepted. Min tx occupancy is 2+WORDS cycles plus 1 idle.
//   - cnt wraps to 0 on exit from TX_DATA.
//  RX FSM: RX_HEAD -> RX_ADDR -> RX_DATA(cnt 0..WORDS-1) -> RX_DELIVER -> RX_HEAD.
//   - flit_in_ready = (state!=RX_DELIVER), registered.
//   - HEAD fields are latched. Address is the low ADDRESS_BITS of the ADDR flit.
//   - Each data word is written into its slot in the line.
//   - RX_DELIVER with dest!=LOCAL_ID: pulse drop_pulse; outputs stay idle; go to RX_HEAD.
//   - RX_DELIVER with dest==LOCAL_ID: drive noc_msg_in/address/data/src from latches.
//     The transfer completes on the first cycle with interface_busy==0.
//     The next cycle noc_msg_in=IDLE_MSG and state returns to RX_HEAD.
//     While interface_busy==1, outputs are held and no flits are accepted (backpressure).
//   - Outside a valid RX_DELIVER: noc_msg_in=IDLE_MSG; address, data and src are 0.
//  Reset (reset==0 at posedge): both FSMs go to idle/HEAD and counters to 0. Partial packets are
//   discarded and not resumed. Output reset values:
//   packetizer_busy=0, flit_out_valid=0, flit_out=0, flit_in_ready=1 (from the first cycle after
//   reset release), noc_msg_in=IDLE_MSG, noc_address_in=0, noc_data_in=0, noc_src_id=0, drop_pulse=0.
//  TX and RX may be active in the same cycle with no interaction. A locally addressed tx packet is
//   not looped back internally.
// TESTING
//  T1 tx: msg=4'h3, addr=32'h0000_1040, line={32'hD3,32'hD2,32'hD1,32'hD0}, dest=2, ready=1 ->
//     flits 32'h8300_0000 (dest=2,src=0,msg=3), 32'h1040, D0, D1, D2, D3 on 6 consecutive cycles;
//     busy high exactly 6 cycles.
//  T2 tx backpressure: as T1 with flit_out_ready toggling 1,0,0,1,... -> each flit held stable
//     until accepted; order unchanged; no duplicated or skipped flit.
//  T3 rx: HEAD dest=0,src=1,msg=5 then ADDR 32'h2000 then D0..D3; interface_busy=0 ->
//     noc_msg_in=5, addr=32'h2000, src=1 for exactly 1 cycle; flit_in_ready=0 during that cycle.
//  T4 rx hold: as T3 with interface_busy=1 for 5 cycles -> outputs held 5 cycles; flit_in_ready=0;
//     delivery on the cycle busy falls; next packet then accepted.
//  T5 wrong dest: HEAD dest=3 -> all 6 flits consumed; drop_pulse=1 for 1 cycle; noc_msg_in stays 0.
//  T6 reset mid-packet: reset=0 after 3 rx flits and 2 tx flits -> next cycle all outputs at reset
//     values; a following full packet is received correctly.

Source files
------------

// File: rtl/noc_packetizer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// noc_packetizer : cache-line message <-> NoC flit serializer / reassembler
// Revision       : 1.0  initial release
// ============================================================================
module noc_packetizer #(
    parameter int MSG_BITS     = 4,
    parameter int ADDRESS_BITS = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int OFFSET_BITS  = 2,
    parameter int ID_BITS      = 2,
    parameter int LOCAL_ID     = 0,
    parameter int IDLE_MSG     = 0
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [MSG_BITS-1:0]                  noc_msg_out,
    input  logic [ADDRESS_BITS-1:0]              noc_address_out,
    input  logic [(DATA_WIDTH<<OFFSET_BITS)-1:0] noc_data_out,
    input  logic [ID_BITS-1:0]                   noc_dest_id,
    output logic                                 packetizer_busy,
    output logic [MSG_BITS-1:0]                  noc_msg_in,
    output logic [ADDRESS_BITS-1:0]              noc_address_in,
    output logic [(DATA_WIDTH<<OFFSET_BITS)-1:0] noc_data_in,
    output logic [ID_BITS-1:0]                   noc_src_id,
    input  logic                                 interface_busy,
    output logic [DATA_WIDTH-1:0]                flit_out,
    output logic                                 flit_out_valid,
    input  logic                                 flit_out_ready,
    input  logic [DATA_WIDTH-1:0]                flit_in,
    input  logic                                 flit_in_valid,
    output logic                                 flit_in_ready,
    output logic                                 drop_pulse
);

    localparam int                      WORDS     = 1 << OFFSET_BITS;
    localparam logic [OFFSET_BITS-1:0]  LAST_WORD = OFFSET_BITS'(WORDS - 1);
    localparam logic [OFFSET_BITS-1:0]  CNT_ONE   = OFFSET_BITS'(1);
    localparam logic [ID_BITS-1:0]      LOCAL     = ID_BITS'(LOCAL_ID);
    localparam logic [MSG_BITS-1:0]     IDLE      = MSG_BITS'(IDLE_MSG);

    localparam logic [1:0] TX_IDLE    = 2'd0;
    localparam logic [1:0] TX_HEAD    = 2'd1;
    localparam logic [1:0] TX_ADDR    = 2'd2;
    localparam logic [1:0] TX_DATA    = 2'd3;

    localparam logic [1:0] RX_HEAD    = 2'd0;
    localparam logic [1:0] RX_ADDR    = 2'd1;
    localparam logic [1:0] RX_DATA    = 2'd2;
    localparam logic [1:0] RX_DELIVER = 2'd3;

    // ------------------------------------------------------------------ TX
    logic [1:0]                            tx_state, tx_state_nxt;
    logic [OFFSET_BITS-1:0]                tx_cnt, tx_cnt_nxt;
    logic [DATA_WIDTH-1:0]                 tx_head_flit, tx_head_new, tx_addr_flit;
    logic [WORDS-1:0][DATA_WIDTH-1:0]      tx_words;
    logic                                  tx_accept;

    assign tx_accept = (tx_state == TX_IDLE) && (noc_msg_out != IDLE);

    always_comb begin
        tx_head_new = '0;
        tx_head_new[DATA_WIDTH-1 -: ID_BITS]             = noc_dest_id;
        tx_head_new[DATA_WIDTH-1-ID_BITS -: ID_BITS]     = LOCAL;
        tx_head_new[DATA_WIDTH-1-2*ID_BITS -: MSG_BITS]  = noc_msg_out;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            tx_head_flit <= '0;
            tx_addr_flit <= '0;
            tx_words     <= '0;
        end else if (tx_accept) begin
            tx_head_flit <= tx_head_new;
            tx_addr_flit <= DATA_WIDTH'(noc_address_out);
            tx_words     <= noc_data_out;
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        case (tx_state)
            TX_IDLE: if (tx_accept) tx_state_nxt = TX_HEAD;
            TX_HEAD: if (flit_out_ready) tx_state_nxt = TX_ADDR;
            TX_ADDR: begin
                if (flit_out_ready) begin
                    tx_state_nxt = TX_DATA;
                    tx_cnt_nxt   = '0;
                end
            end
            TX_DATA: begin
                if (flit_out_ready) begin
                    if (tx_cnt == LAST_WORD) begin
                        tx_state_nxt = TX_IDLE;
                        tx_cnt_nxt   = '0;
                    end else begin
                        tx_cnt_nxt   = tx_cnt + CNT_ONE;
                    end
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    // Outputs depend only on registered state, so the flit is stable while stalled.
    always_comb begin
        flit_out        = '0;
        flit_out_valid  = 1'b0;
        packetizer_busy = 1'b0;
        case (tx_state)
            TX_HEAD: begin
                flit_out        = tx_head_flit;
                flit_out_valid  = 1'b1;
                packetizer_busy = 1'b1;
            end
            TX_ADDR: begin
                flit_out        = tx_addr_flit;
                flit_out_valid  = 1'b1;
                packetizer_busy = 1'b1;
            end
            TX_DATA: begin
                flit_out        = tx_words[tx_cnt];
                flit_out_valid  = 1'b1;
                packetizer_busy = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------ RX
    logic [1:0]                            rx_state, rx_state_nxt;
    logic [OFFSET_BITS-1:0]                rx_cnt, rx_cnt_nxt;
    logic [ID_BITS-1:0]                    rx_dest, rx_src;
    logic [MSG_BITS-1:0]                   rx_msg;
    logic [ADDRESS_BITS-1:0]               rx_addr;
    logic [WORDS-1:0][DATA_WIDTH-1:0]      rx_words;
    logic                                  rx_take;

    assign rx_take = flit_in_valid && flit_in_ready;

    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_state <= RX_HEAD;
            rx_cnt   <= '0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_dest  <= '0;
            rx_src   <= '0;
            rx_msg   <= '0;
            rx_addr  <= '0;
            rx_words <= '0;
        end else if (rx_take) begin
            case (rx_state)
                RX_HEAD: begin
                    rx_dest <= flit_in[DATA_WIDTH-1 -: ID_BITS];
                    rx_src  <= flit_in[DATA_WIDTH-1-ID_BITS -: ID_BITS];
                    rx_msg  <= flit_in[DATA_WIDTH-1-2*ID_BITS -: MSG_BITS];
                end
                RX_ADDR: rx_addr <= flit_in[ADDRESS_BITS-1:0];
                RX_DATA: rx_words[rx_cnt] <= flit_in;
                default: ;
            endcase
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        case (rx_state)
            RX_HEAD: if (rx_take) rx_state_nxt = RX_ADDR;
            RX_ADDR: begin
                if (rx_take) begin
                    rx_state_nxt = RX_DATA;
                    rx_cnt_nxt   = '0;
                end
            end
            RX_DATA: begin
                if (rx_take) begin
                    if (rx_cnt == LAST_WORD) begin
                        rx_state_nxt = RX_DELIVER;
                        rx_cnt_nxt   = '0;
                    end else begin
                        rx_cnt_nxt   = rx_cnt + CNT_ONE;
                    end
                end
            end
            // Foreign packets leave after one cycle regardless of interface backpressure.
            RX_DELIVER: if ((rx_dest != LOCAL) || !interface_busy) rx_state_nxt = RX_HEAD;
            default: rx_state_nxt = RX_HEAD;
        endcase
    end

    always_comb begin
        flit_in_ready  = 1'b1;
        drop_pulse     = 1'b0;
        noc_msg_in     = IDLE;
        noc_address_in = '0;
        noc_data_in    = '0;
        noc_src_id     = '0;
        if (rx_state == RX_DELIVER) begin
            flit_in_ready = 1'b0;
            if (rx_dest != LOCAL) begin
                drop_pulse = 1'b1;
            end else begin
                noc_msg_in     = rx_msg;
                noc_address_in = rx_addr;
                noc_data_in    = rx_words;
                noc_src_id     = rx_src;
            end
        end
    end

endmodule
`default_nettype wire
